// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: expands each 512-bit block into W0..W63 through a
// 16-word sliding window, issuing one word per downstream handshake.
//
// state    | meaning
// ---------+------------------------------------------
// S_IDLE   | no block held; ready for a new block
// S_ACTIVE | block held; words being issued
module sha256_message_schedule (
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         sync_rst,
    input  logic [511:0] data_in,
    input  logic         data_in_last,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [31:0]  data_out,
    output logic [5:0]   data_out_idx,
    output logic         data_out_block_end,
    output logic         data_out_last,
    output logic         data_out_valid,
    input  logic         data_out_ready
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [5:0]  idx_q, idx_d;
    logic        last_q, last_d;

    logic        in_hs, out_hs, final_word;
    logic [31:0] new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign final_word = (idx_q == 6'd63);
    assign in_hs      = data_in_valid & data_in_ready;
    assign out_hs     = data_out_valid & data_out_ready;
    assign new_word   = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new block may load in the same cycle W63 leaves, so IDLE is only
    // entered when nothing is waiting upstream.
    always_comb begin
        state_d = state_q;
        if (sync_rst) begin
            state_d = S_IDLE;
        end else if (in_hs) begin
            state_d = S_ACTIVE;
        end else if (out_hs && final_word) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        data_in_ready      = en & ~sync_rst &
                             ((state_q == S_IDLE) |
                              ((state_q == S_ACTIVE) & final_word & data_out_ready));
        data_out_valid     = en & (state_q == S_ACTIVE);
        data_out           = w_q[0];
        data_out_idx       = idx_q;
        data_out_block_end = (state_q == S_ACTIVE) & final_word;
        data_out_last      = (state_q == S_ACTIVE) & final_word & last_q;
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_d[i] = w_q[i];
        end
        idx_d  = idx_q;
        last_d = last_q;
        if (sync_rst) begin
            for (int i = 0; i < 16; i++) begin
                w_d[i] = '0;
            end
            idx_d  = '0;
            last_d = 1'b0;
        end else if (in_hs) begin
            for (int i = 0; i < 16; i++) begin
                w_d[i] = data_in[511 - 32*i -: 32];
            end
            idx_d  = '0;
            last_d = data_in_last;
        end else if (out_hs && !final_word) begin
            for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i+1];
            end
            w_d[15] = new_word;
            idx_d   = idx_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= w_d[i];
            end
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Self-checking bench for sha256_message_schedule: table of blocks with stall
// profiles, checked word-by-word against a full-array schedule model.
module tb_sha256_message_schedule;

    logic         clk = 1'b0;
    logic         nrst, en, sync_rst;
    logic [511:0] data_in;
    logic         data_in_last, data_in_valid, data_in_ready;
    logic [31:0]  data_out;
    logic [5:0]   data_out_idx;
    logic         data_out_block_end, data_out_last, data_out_valid, data_out_ready;

    sha256_message_schedule dut (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(data_in), .data_in_last(data_in_last),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_idx(data_out_idx),
        .data_out_block_end(data_out_block_end), .data_out_last(data_out_last),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  idx;
        logic        be;
        logic        last;
    } exp_t;

    typedef struct {
        logic [511:0] blk;
        logic         last;
        int           stall;
        logic         has_kat;
        logic [31:0]  kat_w0, kat_w15, kat_w16, kat_w17;
    } row_t;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t         exp_q[$];
    logic [511:0] pend_blk[$];
    logic         pend_last[$];
    logic [31:0]  mw[64];
    logic [31:0]  obs_w[64];
    int stall_max = 0, stall_cnt = 0, budget = 0;
    int valid_run = 0, max_run = 0;
    logic prev_valid = 1'b0, prev_hs = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule over a full 64-entry array.
    task automatic compute(input logic [511:0] b);
        for (int t = 0; t < 16; t++) mw[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            mw[t] = (rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10))
                  + mw[t-7]
                  + (rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3))
                  + mw[t-16];
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic hs;
        @(negedge clk);
        data_in_valid = (pend_blk.size() > 0);
        if (data_in_valid) begin
            data_in      = pend_blk[0];
            data_in_last = pend_last[0];
        end
        if (stall_max == 0) begin
            data_out_ready = 1'b1;
        end else if (stall_cnt > 0) begin
            data_out_ready = 1'b0;
            stall_cnt--;
        end else begin
            data_out_ready = 1'b1;
            stall_cnt = $urandom_range(0, stall_max);
        end
        #1;
        budget--;
        if (!en) begin
            chk("en_low_valid", {63'd0, data_out_valid}, 64'd0);
            chk("en_low_ready", {63'd0, data_in_ready}, 64'd0);
        end
        if (sync_rst) chk("srst_ready", {63'd0, data_in_ready}, 64'd0);
        if (prev_valid && !prev_hs && en && nrst)
            chk("valid_held", {63'd0, data_out_valid}, 64'd1);
        if (data_out_valid) begin
            valid_run++;
            if (valid_run > max_run) max_run = valid_run;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {63'd0, data_out_valid}, 64'd0);
            end else begin
                e = exp_q[0];
                chk($sformatf("word_idx%0d", e.idx),
                    {26'd0, data_out, data_out_idx, data_out_block_end, data_out_last},
                    {26'd0, e.w, e.idx, e.be, e.last});
                if (!(e.idx == 6'd63 && data_out_ready))
                    chk("in_ready_busy", {63'd0, data_in_ready}, 64'd0);
            end
        end else begin
            valid_run = 0;
        end
        hs = data_out_valid && data_out_ready;
        if (hs) begin
            obs_w[data_out_idx] = data_out;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (data_in_valid && data_in_ready) begin
            compute(pend_blk[0]);
            for (int t = 0; t < 64; t++) begin
                e.w = mw[t]; e.idx = 6'(t); e.be = (t == 63); e.last = (t == 63) && pend_last[0];
                exp_q.push_back(e);
            end
            void'(pend_blk.pop_front());
            void'(pend_last.pop_front());
        end
        prev_valid = data_out_valid;
        prev_hs    = hs;
        @(posedge clk);
    endtask

    task automatic run_all();
        budget = 3000;
        while ((exp_q.size() > 0 || pend_blk.size() > 0) && budget > 0) cycle();
        if (budget <= 0) chk("timeout_drain", 64'd1, 64'd0);
        data_in_valid = 1'b0;
    endtask

    task automatic run_to_idx(input int target);
        budget = 3000;
        while (!(exp_q.size() > 0 && exp_q[0].idx == 6'(target)) && budget > 0) cycle();
        if (budget <= 0) chk("timeout_idx", 64'd1, 64'd0);
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    row_t rows[5];
    logic [511:0] abc;

    initial begin
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
        data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b0;
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;

        rows[0] = '{abc,        1'b1, 0, 1'b1, 32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000};
        rows[1] = '{512'd0,     1'b0, 0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
        rows[2] = '{abc,        1'b1, 5, 1'b1, 32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000};
        rows[3] = '{rand_blk(), 1'b1, 3, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        rows[4] = '{rand_blk(), 1'b0, 0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};

        #1;
        chk("rst_valid", {63'd0, data_out_valid}, 64'd0);
        chk("rst_data",  {32'd0, data_out}, 64'd0);
        chk("rst_idx",   {58'd0, data_out_idx}, 64'd0);
        chk("rst_flags", {62'd0, data_out_block_end, data_out_last}, 64'd0);
        chk("rst_in_ready", {63'd0, data_in_ready}, 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk);

        for (int r = 0; r < 5; r++) begin
            stall_max = rows[r].stall; stall_cnt = 0;
            pend_blk.push_back(rows[r].blk);
            pend_last.push_back(rows[r].last);
            run_all();
            if (rows[r].has_kat) begin
                chk("kat_w0",  {32'd0, obs_w[0]},  {32'd0, rows[r].kat_w0});
                chk("kat_w15", {32'd0, obs_w[15]}, {32'd0, rows[r].kat_w15});
                chk("kat_w16", {32'd0, obs_w[16]}, {32'd0, rows[r].kat_w16});
                chk("kat_w17", {32'd0, obs_w[17]}, {32'd0, rows[r].kat_w17});
            end
            @(negedge clk); #1;
            chk("idle_after_w63", {63'd0, data_out_valid}, 64'd0);
            prev_valid = 1'b0;
            @(posedge clk);
        end

        // Back-to-back blocks, continuous ready: 128 valid cycles without a gap.
        stall_max = 0; max_run = 0; valid_run = 0;
        pend_blk.push_back(rand_blk()); pend_last.push_back(1'b0);
        pend_blk.push_back(rand_blk()); pend_last.push_back(1'b1);
        run_all();
        chk("b2b_valid_run", 64'(max_run), 64'd128);

        // Enable pause at idx 30.
        pend_blk.push_back(rand_blk()); pend_last.push_back(1'b1);
        run_to_idx(30);
        en = 1'b0;
        repeat (4) cycle();
        en = 1'b1;
        prev_valid = 1'b0;
        run_all();

        // Synchronous reset mid-block at idx 20.
        pend_blk.push_back(abc); pend_last.push_back(1'b1);
        run_to_idx(20);
        sync_rst = 1'b1;
        cycle();
        sync_rst = 1'b0;
        exp_q.delete();
        prev_valid = 1'b0;
        @(negedge clk); #1;
        chk("srst_valid", {63'd0, data_out_valid}, 64'd0);
        chk("srst_data",  {32'd0, data_out}, 64'd0);
        chk("srst_idx",   {58'd0, data_out_idx}, 64'd0);
        @(posedge clk);

        // Asynchronous reset at idx 5 of a reloaded block; handshake during reset ignored.
        pend_blk.push_back(rand_blk()); pend_last.push_back(1'b0);
        run_to_idx(5);
        nrst = 1'b0;
        data_in_valid = 1'b1;
        exp_q.delete();
        #1;
        chk("nrst_valid", {63'd0, data_out_valid}, 64'd0);
        chk("nrst_in_ready", {63'd0, data_in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        data_in_valid = 1'b0;
        #1;
        chk("nrst_ignored_hs", {63'd0, data_out_valid}, 64'd0);
        prev_valid = 1'b0;
        @(posedge clk);
        pend_blk.push_back(abc); pend_last.push_back(1'b1);
        run_all();
        chk("reload_w0", {32'd0, obs_w[0]}, {32'd0, 32'h61626380});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
